// File: rtl/elevator_pkg.sv
// Types and sizes shared by the call panel and the elevator controller.
package elevator_pkg;

  localparam int N_FLOORS = 5;
  localparam int FLOOR_W  = 3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} call_state_t;
  typedef enum logic [1:0] {G_IDLE, G_OUT1, G_IN1, G_HOLD} gate_state_t;

  // Floors are numbered from 1, so out-of-range positions (0, > N_FLOORS) never match.
  function automatic logic floor_is(input logic [FLOOR_W-1:0] floor_num, input int idx);
    return floor_num == FLOOR_W'(idx + 1);
  endfunction

endpackage

// File: rtl/call_debounce.sv
// One push-button: 2-flop synchroniser followed by a debounce counter.
// rise pulses for one cycle on the edge where the debounced level goes high.
module call_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_reg, sync2_reg, level_reg, rise_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      rise_reg  <= 1'b0;
      // Any sample agreeing with the current level restarts the count.
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_reg <= sync2_reg;
        rise_reg  <= sync2_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign rise = rise_reg;

endmodule

// File: rtl/call_panel.sv
// Landing/car front end: debounced call buttons with latched lamps, and a
// two-beam doorway decoder producing come_in / go_out pulses.
module call_panel
  import elevator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] btn_raw,
  input  logic                beam_outer,
  input  logic                beam_inner,
  input  logic [FLOOR_W-1:0]  current_floor,
  input  logic                going_up,
  input  logic                going_down,
  output logic [N_FLOORS-1:0] buttons,
  output logic [N_FLOORS-1:0] call_lamp,
  output logic                come_in,
  output logic                go_out
);

  logic [N_FLOORS-1:0] rise;
  logic                moving;

  assign moving = going_up || going_down;

  genvar gi;
  generate
    for (gi = 0; gi < N_FLOORS; gi++) begin : g_floor
      call_state_t state_reg, state_next;
      logic        press_reg;
      logic        stop;

      call_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk   (clk),
        .reset (reset),
        .raw   (btn_raw[gi]),
        .rise  (rise[gi])
      );

      assign stop = !moving && floor_is(current_floor, gi);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state_reg <= IDLE;
          press_reg <= 1'b0;
        end else begin
          state_reg <= state_next;
          press_reg <= rise[gi];
        end
      end

      always_comb begin
        state_next = state_reg;
        case (state_reg)
          IDLE:    if (press_reg) state_next = ISSUE;
          ISSUE:   state_next = WAIT;
          WAIT:    if (stop) state_next = IDLE;
          default: state_next = IDLE;
        endcase
      end

      assign buttons[gi]   = (state_reg == ISSUE);
      assign call_lamp[gi] = (state_reg != IDLE);
    end
  endgenerate

  logic        o_s1_reg, o_s2_reg, n_s1_reg, n_s2_reg;
  logic        come_in_reg, come_in_next, go_out_reg, go_out_next;
  gate_state_t gate_reg, gate_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_s1_reg    <= 1'b0;
      o_s2_reg    <= 1'b0;
      n_s1_reg    <= 1'b0;
      n_s2_reg    <= 1'b0;
      gate_reg    <= G_IDLE;
      come_in_reg <= 1'b0;
      go_out_reg  <= 1'b0;
    end else begin
      o_s1_reg    <= beam_outer;
      o_s2_reg    <= o_s1_reg;
      n_s1_reg    <= beam_inner;
      n_s2_reg    <= n_s1_reg;
      gate_reg    <= gate_next;
      come_in_reg <= come_in_next;
      go_out_reg  <= go_out_next;
    end
  end

  // HOLD absorbs everything until both beams clear, so one passage yields at most one pulse.
  always_comb begin
    gate_next    = gate_reg;
    come_in_next = 1'b0;
    go_out_next  = 1'b0;
    case (gate_reg)
      G_IDLE: begin
        if (o_s2_reg && n_s2_reg) gate_next = G_HOLD;
        else if (o_s2_reg)        gate_next = G_OUT1;
        else if (n_s2_reg)        gate_next = G_IN1;
      end
      G_OUT1: begin
        if (moving) begin
          gate_next = G_HOLD;
        end else if (n_s2_reg) begin
          come_in_next = 1'b1;
          gate_next    = G_HOLD;
        end else if (!o_s2_reg) begin
          gate_next = G_IDLE;
        end
      end
      G_IN1: begin
        if (moving) begin
          gate_next = G_HOLD;
        end else if (o_s2_reg) begin
          go_out_next = 1'b1;
          gate_next   = G_HOLD;
        end else if (!n_s2_reg) begin
          gate_next = G_IDLE;
        end
      end
      G_HOLD:  if (!o_s2_reg && !n_s2_reg) gate_next = G_IDLE;
      default: gate_next = G_IDLE;
    endcase
  end

  assign come_in = come_in_reg;
  assign go_out  = go_out_reg;

endmodule

// File: tb/tb_call_panel.sv
// Directed bench for call_panel: buttons, lamps, doorway gate and reset behaviour.
module tb_call_panel;
  import elevator_pkg::*;

  logic                clk = 1'b0;
  logic                reset;
  logic [N_FLOORS-1:0] btn_raw;
  logic                beam_outer, beam_inner;
  logic [FLOOR_W-1:0]  current_floor;
  logic                going_up, going_down;
  logic [N_FLOORS-1:0] buttons, call_lamp;
  logic                come_in, go_out;

  int checks = 0;
  int passed = 0;

  int                  bc, bf, cc, cf, gc, gf;
  logic [N_FLOORS-1:0] bv;

  always #5 clk = ~clk;

  call_panel dut (
    .clk           (clk),
    .reset         (reset),
    .btn_raw       (btn_raw),
    .beam_outer    (beam_outer),
    .beam_inner    (beam_inner),
    .current_floor (current_floor),
    .going_up      (going_up),
    .going_down    (going_down),
    .buttons       (buttons),
    .call_lamp     (call_lamp),
    .come_in       (come_in),
    .go_out        (go_out)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Observe n cycles; index k means "sampled after the k-th edge since the last drive" (0-based).
  task automatic watch(input int n, output int b_cnt, output int b_first, output logic [N_FLOORS-1:0] b_val,
                       output int c_cnt, output int c_first, output int g_cnt, output int g_first);
    b_cnt = 0; b_first = -1; b_val = '0;
    c_cnt = 0; c_first = -1; g_cnt = 0; g_first = -1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (buttons != '0) begin
        if (b_cnt == 0) begin b_first = k; b_val = buttons; end
        b_cnt++;
      end
      if (come_in) begin if (c_cnt == 0) c_first = k; c_cnt++; end
      if (go_out)  begin if (g_cnt == 0) g_first = k; g_cnt++; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; btn_raw = '1; beam_outer = 1'b1; beam_inner = 1'b1;
    current_floor = 3'd1; going_up = 1'b0; going_down = 1'b0;
    tick(4);
    checks++; if (buttons !== 5'b0)   $display("FAIL reset_buttons: got %b expected %b", buttons, 5'b0); else passed++;
    checks++; if (call_lamp !== 5'b0) $display("FAIL reset_lamp: got %b expected %b", call_lamp, 5'b0); else passed++;
    checks++; if (come_in !== 1'b0)   $display("FAIL reset_come_in: got %b expected 0", come_in); else passed++;
    checks++; if (go_out !== 1'b0)    $display("FAIL reset_go_out: got %b expected 0", go_out); else passed++;
    btn_raw = '0; beam_outer = 1'b0; beam_inner = 1'b0;
    tick(1);
    reset = 1'b1;
    watch(12, bc, bf, bv, cc, cf, gc, gf);
    checks++; if (bc != 0) $display("FAIL release_buttons: got %0d pulses expected 0", bc); else passed++;
    checks++; if (cc + gc != 0) $display("FAIL release_gate: got %0d pulses expected 0", cc + gc); else passed++;
    checks++; if (call_lamp !== 5'b0) $display("FAIL release_lamp: got %b expected %b", call_lamp, 5'b0); else passed++;
    $display("test_reset: done");
  endtask

  task automatic test_glitch;
    tick(4);
    btn_raw = 5'b00100;
    tick(3);
    btn_raw = 5'b00000;
    watch(12, bc, bf, bv, cc, cf, gc, gf);
    checks++; if (bc != 0) $display("FAIL glitch_pulse: got %0d pulses expected 0", bc); else passed++;
    checks++; if (call_lamp !== 5'b0) $display("FAIL glitch_lamp: got %b expected %b", call_lamp, 5'b0); else passed++;
    $display("test_glitch: %0d pulses", bc);
  endtask

  task automatic test_press;
    tick(4);
    current_floor = 3'd3; going_up = 1'b1;
    btn_raw = 5'b00100;
    watch(12, bc, bf, bv, cc, cf, gc, gf);
    checks++; if (bc != 1) $display("FAIL press_count: got %0d pulses expected 1", bc); else passed++;
    checks++; if (bf != 7) $display("FAIL press_latency: got edge %0d expected 7", bf); else passed++;
    checks++; if (bv !== 5'b00100) $display("FAIL press_value: got %b expected %b", bv, 5'b00100); else passed++;
    checks++; if (call_lamp !== 5'b00100) $display("FAIL press_lamp_moving: got %b expected %b", call_lamp, 5'b00100); else passed++;
    btn_raw = 5'b0; going_down = 1'b1;
    tick(2);
    checks++; if (call_lamp !== 5'b00100) $display("FAIL press_lamp_both_flags: got %b expected %b", call_lamp, 5'b00100); else passed++;
    current_floor = 3'd7; going_up = 1'b0; going_down = 1'b0;
    tick(2);
    checks++; if (call_lamp !== 5'b00100) $display("FAIL press_lamp_bad_floor: got %b expected %b", call_lamp, 5'b00100); else passed++;
    current_floor = 3'd3;
    tick(1);
    checks++; if (call_lamp !== 5'b00000) $display("FAIL press_lamp_clear: got %b expected %b", call_lamp, 5'b00000); else passed++;
    $display("test_press: pulse at edge %0d value %b", bf, bv);
  endtask

  task automatic test_idle_floor;
    tick(8);
    current_floor = 3'd2; going_up = 1'b0; going_down = 1'b0;
    btn_raw = 5'b00010;
    tick(8);
    checks++; if (buttons !== 5'b00010)   $display("FAIL idle_issue_btn: got %b expected %b", buttons, 5'b00010); else passed++;
    checks++; if (call_lamp !== 5'b00010) $display("FAIL idle_issue_lamp: got %b expected %b", call_lamp, 5'b00010); else passed++;
    tick(1);
    checks++; if (buttons !== 5'b00000)   $display("FAIL idle_wait_btn: got %b expected %b", buttons, 5'b00000); else passed++;
    checks++; if (call_lamp !== 5'b00010) $display("FAIL idle_wait_lamp: got %b expected %b", call_lamp, 5'b00010); else passed++;
    tick(1);
    checks++; if (call_lamp !== 5'b00000) $display("FAIL idle_clear_lamp: got %b expected %b", call_lamp, 5'b00000); else passed++;
    btn_raw = 5'b0;
    tick(8);
    $display("test_idle_floor: done");
  endtask

  task automatic test_repress;
    int extra;
    current_floor = 3'd1; going_up = 1'b1;
    btn_raw = 5'b10000;
    watch(10, bc, bf, bv, cc, cf, gc, gf);
    checks++; if (bc != 1 || bv !== 5'b10000) $display("FAIL repress_first: got %0d pulses value %b expected 1 pulse %b", bc, bv, 5'b10000); else passed++;
    checks++; if (call_lamp !== 5'b10000) $display("FAIL repress_lamp_set: got %b expected %b", call_lamp, 5'b10000); else passed++;
    extra = 0;
    for (int r = 0; r < 2; r++) begin
      btn_raw = 5'b00000;
      watch(8, bc, bf, bv, cc, cf, gc, gf); extra += bc;
      btn_raw = 5'b10000;
      watch(8, bc, bf, bv, cc, cf, gc, gf); extra += bc;
    end
    btn_raw = 5'b00000;
    checks++; if (extra != 0) $display("FAIL repress_extra: got %0d pulses expected 0", extra); else passed++;
    current_floor = 3'd5;
    tick(2);
    checks++; if (call_lamp !== 5'b10000) $display("FAIL repress_passing: got %b expected %b", call_lamp, 5'b10000); else passed++;
    going_up = 1'b0;
    tick(1);
    checks++; if (call_lamp !== 5'b00000) $display("FAIL repress_stop: got %b expected %b", call_lamp, 5'b00000); else passed++;
    tick(8);
    $display("test_repress: %0d extra pulses", extra);
  endtask

  task automatic test_gate_entry;
    beam_outer = 1'b1;
    tick(2);
    beam_inner = 1'b1;
    watch(6, bc, bf, bv, cc, cf, gc, gf);
    checks++; if (cc != 1)  $display("FAIL entry_count: got %0d come_in expected 1", cc); else passed++;
    checks++; if (cf != 2)  $display("FAIL entry_latency: got edge %0d expected 2", cf); else passed++;
    checks++; if (gc != 0)  $display("FAIL entry_go_out: got %0d go_out expected 0", gc); else passed++;
    beam_outer = 1'b0; beam_inner = 1'b0;
    watch(6, bc, bf, bv, cc, cf, gc, gf);
    checks++; if (cc + gc != 0) $display("FAIL entry_clear: got %0d pulses expected 0", cc + gc); else passed++;
    $display("test_gate_entry: come_in at edge %0d", cf);
  endtask

  task automatic test_gate_exit;
    beam_inner = 1'b1;
    tick(2);
    beam_outer = 1'b1;
    watch(6, bc, bf, bv, cc, cf, gc, gf);
    checks++; if (gc != 1 || gf != 2) $display("FAIL exit_go_out: got %0d at edge %0d expected 1 at edge 2", gc, gf); else passed++;
    checks++; if (cc != 0) $display("FAIL exit_come_in: got %0d come_in expected 0", cc); else passed++;
    beam_outer = 1'b0; beam_inner = 1'b0;
    watch(6, bc, bf, bv, cc, cf, gc, gf);
    checks++; if (cc + gc != 0) $display("FAIL exit_clear: got %0d pulses expected 0", cc + gc); else passed++;
    $display("test_gate_exit: go_out at edge %0d", gf);
  endtask

  task automatic test_gate_abort;
    beam_outer = 1'b1;
    tick(3);
    beam_outer = 1'b0;
    watch(8, bc, bf, bv, cc, cf, gc, gf);
    checks++; if (cc + gc != 0) $display("FAIL abort_outer: got %0d pulses expected 0", cc + gc); else passed++;
    beam_outer = 1'b1; beam_inner = 1'b1;
    watch(6, bc, bf, bv, cc, cf, gc, gf);
    checks++; if (cc + gc != 0) $display("FAIL abort_both: got %0d pulses expected 0", cc + gc); else passed++;
    beam_outer = 1'b0; beam_inner = 1'b0;
    watch(6, bc, bf, bv, cc, cf, gc, gf);
    checks++; if (cc + gc != 0) $display("FAIL abort_both_clear: got %0d pulses expected 0", cc + gc); else passed++;
    $display("test_gate_abort: done");
  endtask

  task automatic test_motion;
    going_down = 1'b1;
    beam_outer = 1'b1;
    tick(2);
    beam_inner = 1'b1;
    watch(6, bc, bf, bv, cc, cf, gc, gf);
    checks++; if (cc + gc != 0) $display("FAIL motion_pulse: got %0d pulses expected 0", cc + gc); else passed++;
    beam_outer = 1'b0; beam_inner = 1'b0; going_down = 1'b0;
    watch(6, bc, bf, bv, cc, cf, gc, gf);
    checks++; if (cc + gc != 0) $display("FAIL motion_clear: got %0d pulses expected 0", cc + gc); else passed++;
    $display("test_motion: done");
  endtask

  task automatic test_back_to_back;
    int total_in, total_out;
    total_in = 0; total_out = 0;
    for (int r = 0; r < 2; r++) begin
      beam_outer = 1'b1;
      tick(2);
      beam_inner = 1'b1;
      watch(6, bc, bf, bv, cc, cf, gc, gf); total_in += cc; total_out += gc;
      beam_outer = 1'b0; beam_inner = 1'b0;
      watch(6, bc, bf, bv, cc, cf, gc, gf); total_in += cc; total_out += gc;
    end
    checks++; if (total_in != 2)  $display("FAIL b2b_come_in: got %0d expected 2", total_in); else passed++;
    checks++; if (total_out != 0) $display("FAIL b2b_go_out: got %0d expected 0", total_out); else passed++;
    $display("test_back_to_back: %0d entries", total_in);
  endtask

  task automatic test_midop_reset;
    current_floor = 3'd2; going_up = 1'b1;
    btn_raw = 5'b01001;
    watch(10, bc, bf, bv, cc, cf, gc, gf);
    checks++; if (bc != 1 || bv !== 5'b01001) $display("FAIL midop_issue: got %0d pulses value %b expected 1 pulse %b", bc, bv, 5'b01001); else passed++;
    btn_raw = 5'b00000;
    tick(8);
    checks++; if (call_lamp !== 5'b01001) $display("FAIL midop_wait_lamp: got %b expected %b", call_lamp, 5'b01001); else passed++;
    reset = 1'b0;
    #1;
    checks++; if (call_lamp !== 5'b00000) $display("FAIL midop_async_lamp: got %b expected %b", call_lamp, 5'b00000); else passed++;
    tick(2);
    reset = 1'b1;
    watch(12, bc, bf, bv, cc, cf, gc, gf);
    checks++; if (bc != 0) $display("FAIL midop_release_pulse: got %0d pulses expected 0", bc); else passed++;
    checks++; if (call_lamp !== 5'b00000) $display("FAIL midop_release_lamp: got %b expected %b", call_lamp, 5'b00000); else passed++;
    $display("test_midop_reset: done");
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_press();
    test_idle_floor();
    test_repress();
    test_gate_entry();
    test_gate_exit();
    test_gate_abort();
    test_motion();
    test_back_to_back();
    test_midop_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
